// File: rtl/ioctl_rom_dip_loader_if.sv
// ----------------------------------------------------------------------------
// ioctl_rom_dip_loader_if
// Byte-stream bus between hps_io (master) and the ROM/DIP loader (slave).
//   ioctl_download : a download is in progress
//   ioctl_index    : download target selector
//   ioctl_wr       : one-cycle byte strobe
//   ioctl_addr     : byte address within the current download
//   ioctl_dout     : byte data
// ----------------------------------------------------------------------------
interface ioctl_rom_dip_loader_if #(
    parameter int ADDR_W = 25
) ();
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;

    modport master (
        output ioctl_download,
        output ioctl_index,
        output ioctl_wr,
        output ioctl_addr,
        output ioctl_dout
    );

    modport slave (
        input  ioctl_download,
        input  ioctl_index,
        input  ioctl_wr,
        input  ioctl_addr,
        input  ioctl_dout
    );
endinterface

// File: rtl/ioctl_rom_dip_loader.sv
// ----------------------------------------------------------------------------
// ioctl_rom_dip_loader
// Download sink between hps_io's ioctl stream and an arcade core. ROM bytes are
// forwarded to the core's download port, DIP bytes and the mod byte are
// captured, and a core reset is generated that covers the ROM download and is
// stretched for HOLD_CYCLES afterwards.
//
// Ports:
//   clk_sys      : system clock
//   reset_n      : asynchronous active-low reset
//   ioctl        : ioctl byte stream (slave side)
//   user_reset   : OSD/button reset request
//   dl_addr/dl_data/dl_wr : registered ROM write port to the core
//   sw           : DIP bank, byte k on sw[8k+7:8k]
//   mod          : mod byte
//   rom_download : ROM download active (combinational)
//   rom_loaded   : sticky, a complete ROM download plus hold has finished
//   rom_overflow : sticky, a ROM byte addressed beyond the dl_addr range
//   core_reset   : active-high reset to the core
// ----------------------------------------------------------------------------
module ioctl_rom_dip_loader #(
    parameter int         ADDR_W      = 25,
    parameter int         DL_ADDR_W   = 17,
    parameter int         NUM_DIP     = 8,
    parameter logic [7:0] ROM_INDEX   = 8'd0,
    parameter logic [7:0] MOD_INDEX   = 8'd1,
    parameter logic [7:0] DIP_INDEX   = 8'd254,
    parameter int         HOLD_CYCLES = 1024
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    ioctl_rom_dip_loader_if.slave  ioctl,
    input  logic                   user_reset,
    output logic [DL_ADDR_W-1:0]   dl_addr,
    output logic [7:0]             dl_data,
    output logic                   dl_wr,
    output logic [8*NUM_DIP-1:0]   sw,
    output logic [7:0]             mod,
    output logic                   rom_download,
    output logic                   rom_loaded,
    output logic                   rom_overflow,
    output logic                   core_reset
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic                 rom_wr;
    logic                 addr_in_range;
    logic                 dip_wr;
    logic                 mod_wr;
    logic                 ovf_set;
    logic                 enter_load;
    logic                 loaded_set;
    logic                 core_reset_next;

    logic [1:0]           state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic                 dl_wr_reg;
    logic [DL_ADDR_W-1:0] dl_addr_reg;
    logic [7:0]           dl_data_reg;
    logic [7:0]           mod_reg;
    logic                 rom_loaded_reg;
    logic                 rom_overflow_reg;
    logic                 core_reset_reg;

    assign rom_download  = ioctl.ioctl_download && (ioctl.ioctl_index == ROM_INDEX);
    assign rom_wr        = ioctl.ioctl_wr && rom_download;
    // Any set bit above the core's address range means the byte cannot land.
    assign addr_in_range = (ioctl.ioctl_addr >> DL_ADDR_W) == '0;
    assign ovf_set       = rom_wr && !addr_in_range;
    assign dip_wr        = ioctl.ioctl_wr && (ioctl.ioctl_index == DIP_INDEX);
    assign mod_wr        = ioctl.ioctl_wr && (ioctl.ioctl_index == MOD_INDEX);

    // ROM write port: one-cycle strobe, address/data hold between writes.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_wr_reg   <= 1'b0;
            dl_addr_reg <= '0;
            dl_data_reg <= '0;
        end else begin
            dl_wr_reg <= rom_wr && addr_in_range;
            if (rom_wr && addr_in_range) begin
                dl_addr_reg <= ioctl.ioctl_addr[DL_ADDR_W-1:0];
                dl_data_reg <= ioctl.ioctl_dout;
            end
        end
    end

    // DIP bank: one register per byte. Matching the address exactly against
    // the byte number also drops every address >= NUM_DIP.
    generate
        for (genvar gi = 0; gi < NUM_DIP; gi++) begin : g_dip
            logic [7:0] byte_reg;
            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    byte_reg <= '0;
                end else if (dip_wr && (ioctl.ioctl_addr == ADDR_W'(gi))) begin
                    byte_reg <= ioctl.ioctl_dout;
                end
            end
            assign sw[8*gi +: 8] = byte_reg;
        end
    endgenerate

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mod_reg <= '0;
        end else if (mod_wr) begin
            mod_reg <= ioctl.ioctl_dout;
        end
    end

    // Reset sequencer.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        loaded_set = 1'b0;
        case (state_reg)
            ST_IDLE: state_next = rom_download ? ST_LOAD : ST_RUN;
            ST_RUN: begin
                if (rom_download) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (!rom_download) begin
                    state_next = ST_HOLD;
                    cnt_next   = CNT_LOAD;
                end
            end
            ST_HOLD: begin
                if (rom_download) begin
                    state_next = ST_LOAD;
                end else if (cnt_reg == '0) begin
                    state_next = ST_RUN;
                    loaded_set = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign enter_load = (state_next == ST_LOAD) && (state_reg != ST_LOAD);
    // Registered from the next state so the reset releases on the same edge
    // the sequencer reaches RUN.
    assign core_reset_next = (state_next == ST_RUN) ? user_reset : 1'b1;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            rom_loaded_reg   <= 1'b0;
            rom_overflow_reg <= 1'b0;
            core_reset_reg   <= 1'b1;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            core_reset_reg <= core_reset_next;
            if (loaded_set) rom_loaded_reg <= 1'b1;
            // An out-of-range byte in the very first cycle of a new download
            // belongs to that download, so the set wins over the entry clear.
            if (ovf_set) begin
                rom_overflow_reg <= 1'b1;
            end else if (enter_load) begin
                rom_overflow_reg <= 1'b0;
            end
        end
    end

    assign dl_wr        = dl_wr_reg;
    assign dl_addr      = dl_addr_reg;
    assign dl_data      = dl_data_reg;
    assign mod          = mod_reg;
    assign rom_loaded   = rom_loaded_reg;
    assign rom_overflow = rom_overflow_reg;
    assign core_reset   = core_reset_reg;

endmodule

// File: tb/tb_ioctl_rom_dip_loader.sv
// ----------------------------------------------------------------------------
// tb_ioctl_rom_dip_loader
// Table-driven vectors, hand-written sequences for the reset-stretch corner
// cases, and a randomized phase, all checked cycle by cycle against a
// behavioural model of the loader's rules.
// ----------------------------------------------------------------------------
module tb_ioctl_rom_dip_loader;

    localparam int HOLD = 16;

    logic         clk_sys = 1'b0;
    logic         reset_n = 1'b1;
    logic         user_reset = 1'b0;
    logic [16:0]  dl_addr;
    logic [7:0]   dl_data;
    logic         dl_wr;
    logic [63:0]  sw;
    logic [7:0]   mod;
    logic         rom_download;
    logic         rom_loaded;
    logic         rom_overflow;
    logic         core_reset;

    ioctl_rom_dip_loader_if #(.ADDR_W(25)) bus ();

    ioctl_rom_dip_loader #(
        .ADDR_W(25), .DL_ADDR_W(17), .NUM_DIP(8),
        .ROM_INDEX(8'd0), .MOD_INDEX(8'd1), .DIP_INDEX(8'd254),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl(bus),
        .user_reset(user_reset), .dl_addr(dl_addr), .dl_data(dl_data),
        .dl_wr(dl_wr), .sw(sw), .mod(mod), .rom_download(rom_download),
        .rom_loaded(rom_loaded), .rom_overflow(rom_overflow),
        .core_reset(core_reset)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- behavioural model ----------------
    logic        m_dl_wr;
    logic [16:0] m_dl_addr;
    logic [7:0]  m_dl_data;
    logic [7:0]  m_sw [8];
    logic [7:0]  m_mod;
    logic        m_loaded, m_ovf, m_core_reset;
    bit          m_seen, m_prev_hi;
    int          m_low_run;

    task automatic model_reset();
        m_dl_wr = 0; m_dl_addr = 0; m_dl_data = 0; m_mod = 0;
        for (int k = 0; k < 8; k++) m_sw[k] = 0;
        m_loaded = 0; m_ovf = 0; m_core_reset = 1;
        m_seen = 0; m_prev_hi = 0; m_low_run = 0;
    endtask

    // Applies the rules for one clock edge given that cycle's inputs.
    task automatic model_update(input logic dl, input logic [7:0] idx,
                                input logic wr, input logic [24:0] addr,
                                input logic [7:0] dout, input logic ur);
        bit hi, ovf_hit;
        hi = dl && (idx == 8'd0);
        ovf_hit = 0;
        m_dl_wr = 0;
        if (wr && hi) begin
            if (addr < 25'h20000) begin
                m_dl_wr = 1; m_dl_addr = addr[16:0]; m_dl_data = dout;
            end else begin
                ovf_hit = 1;
            end
        end
        if (wr && idx == 8'd254 && addr < 25'd8) m_sw[addr[2:0]] = dout;
        if (wr && idx == 8'd1) m_mod = dout;
        if (hi && !m_prev_hi) m_ovf = 0;
        if (ovf_hit) m_ovf = 1;
        m_prev_hi = hi;
        if (hi) begin
            m_low_run = 0; m_seen = 1;
        end else if (m_low_run < 100000) begin
            m_low_run++;
        end
        // Core held while downloading and for HOLD+1 low cycles afterwards.
        if (hi) m_core_reset = 1;
        else if (m_seen && m_low_run <= HOLD) m_core_reset = 1;
        else m_core_reset = ur;
        if (!hi && m_seen && m_low_run > HOLD) m_loaded = 1;
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [63:0] exp_sw;
        for (int k = 0; k < 8; k++) exp_sw[8*k +: 8] = m_sw[k];
        check("dl_wr", dl_wr, m_dl_wr);
        check("dl_addr", dl_addr, m_dl_addr);
        check("dl_data", dl_data, m_dl_data);
        check("sw", sw, exp_sw);
        check("mod", mod, m_mod);
        check("rom_loaded", rom_loaded, m_loaded);
        check("rom_overflow", rom_overflow, m_ovf);
        check("core_reset", core_reset, m_core_reset);
        check("rom_download", rom_download,
              bus.ioctl_download && (bus.ioctl_index == 8'd0));
    endtask

    // One clock: capture inputs, let the edge happen, compare with the model.
    task automatic step();
        logic dl, wr, ur;
        logic [7:0] idx, dout;
        logic [24:0] addr;
        dl = bus.ioctl_download; idx = bus.ioctl_index; wr = bus.ioctl_wr;
        addr = bus.ioctl_addr; dout = bus.ioctl_dout; ur = user_reset;
        @(posedge clk_sys);
        #1;
        model_update(dl, idx, wr, addr, dout, ur);
        compare_all();
        $display("[TB] t=%0t dl=%0b idx=%0d wr=%0b addr=%0h dout=%0h -> dl_wr=%0b core_reset=%0b",
                 $time, dl, idx, wr, addr, dout, dl_wr, core_reset);
    endtask

    task automatic drive(input logic dl, input logic [7:0] idx, input logic wr,
                         input logic [24:0] addr, input logic [7:0] dout);
        bus.ioctl_download = dl; bus.ioctl_index = idx; bus.ioctl_wr = wr;
        bus.ioctl_addr = addr; bus.ioctl_dout = dout;
    endtask

    // Asynchronous reset pulse placed mid-cycle, checked before any edge.
    task automatic do_reset();
        #3 reset_n = 1'b0;
        #1;
        check("rst_dl_wr", dl_wr, 0);
        check("rst_dl_addr", dl_addr, 0);
        check("rst_dl_data", dl_data, 0);
        check("rst_sw", sw, 0);
        check("rst_mod", mod, 0);
        check("rst_rom_loaded", rom_loaded, 0);
        check("rst_rom_overflow", rom_overflow, 0);
        check("rst_core_reset", core_reset, 1);
        @(posedge clk_sys);
        #1;
        check("rst_core_reset_held", core_reset, 1);
        #3 reset_n = 1'b1;
        model_reset();
        #1;
        check("rst_release_core_reset", core_reset, 1);
        $display("[TB] t=%0t async reset pulse", $time);
    endtask

    // ROM download already dropped by the caller; core reset must fall on
    // exactly the (HOLD+1)th edge.
    task automatic expect_hold(input logic loaded_before);
        for (int i = 1; i <= HOLD + 1; i++) begin
            step();
            check("hold_core_reset", core_reset, (i < HOLD + 1));
            if (i == HOLD) check("hold_rom_loaded_early", rom_loaded, loaded_before);
        end
        check("hold_rom_loaded", rom_loaded, 1);
    endtask

    typedef struct {
        logic        dl;
        logic [7:0]  idx;
        logic        wr;
        logic [24:0] addr;
        logic [7:0]  dout;
        logic        exp_dl_wr;
        logic [16:0] exp_dl_addr;
        logic [7:0]  exp_dl_data;
        logic        exp_core_reset;
    } vec_t;

    vec_t vecs[$];

    task automatic apply_vec(input int n);
        drive(vecs[n].dl, vecs[n].idx, vecs[n].wr, vecs[n].addr, vecs[n].dout);
        step();
        check("vec_dl_wr", dl_wr, vecs[n].exp_dl_wr);
        check("vec_dl_addr", dl_addr, vecs[n].exp_dl_addr);
        check("vec_dl_data", dl_data, vecs[n].exp_dl_data);
        check("vec_core_reset", core_reset, vecs[n].exp_core_reset);
    endtask

    initial begin
        bit          active;
        logic [7:0]  ridx;
        logic [24:0] actr;
        logic [7:0]  idx_pool [5];

        // ROM download of A5,5A,FF,00 at 0..3 (rows 0..6).
        vecs.push_back(vec_t'{1'b1, 8'd0, 1'b0, 25'd0, 8'h00, 1'b0, 17'd0, 8'h00, 1'b1});
        vecs.push_back(vec_t'{1'b1, 8'd0, 1'b1, 25'd0, 8'hA5, 1'b1, 17'd0, 8'hA5, 1'b1});
        vecs.push_back(vec_t'{1'b1, 8'd0, 1'b0, 25'd0, 8'h00, 1'b0, 17'd0, 8'hA5, 1'b1});
        vecs.push_back(vec_t'{1'b1, 8'd0, 1'b1, 25'd1, 8'h5A, 1'b1, 17'd1, 8'h5A, 1'b1});
        vecs.push_back(vec_t'{1'b1, 8'd0, 1'b1, 25'd2, 8'hFF, 1'b1, 17'd2, 8'hFF, 1'b1});
        vecs.push_back(vec_t'{1'b1, 8'd0, 1'b0, 25'd0, 8'h00, 1'b0, 17'd2, 8'hFF, 1'b1});
        vecs.push_back(vec_t'{1'b1, 8'd0, 1'b1, 25'd3, 8'h00, 1'b1, 17'd3, 8'h00, 1'b1});
        // DIP bytes at 0..9 (rows 7..16), then two mod bytes (rows 17..18).
        for (int a = 0; a < 10; a++)
            vecs.push_back(vec_t'{1'b1, 8'd254, 1'b1, 25'(a), 8'(8'h10 + a),
                                  1'b0, 17'd3, 8'h00, 1'b0});
        vecs.push_back(vec_t'{1'b1, 8'd1, 1'b1, 25'd0, 8'h3C, 1'b0, 17'd3, 8'h00, 1'b0});
        vecs.push_back(vec_t'{1'b1, 8'd1, 1'b1, 25'd0, 8'hC3, 1'b0, 17'd3, 8'h00, 1'b0});

        drive(0, 8'd0, 0, 25'd0, 8'h00);
        model_reset();

        // Reset release with no download.
        do_reset();
        step();
        check("release_core_reset_low", core_reset, 0);
        step();

        // ROM download and stretched core reset.
        for (int n = 0; n <= 6; n++) apply_vec(n);
        drive(0, 8'd0, 0, 25'd0, 8'h00);
        expect_hold(1'b0);

        // DIP and mod bytes while the core runs.
        for (int n = 7; n < vecs.size(); n++) apply_vec(n);
        check("dip_bank", sw, 64'h1716151413121110);
        check("mod_last_wins", mod, 8'hC3);
        drive(0, 8'd254, 0, 25'd0, 8'h00);
        step();

        // Overflow, then cleared at the start of the next ROM download.
        drive(1, 8'd0, 0, 25'd0, 8'h00);
        step();
        drive(1, 8'd0, 1, 25'h20000, 8'h77);
        step();
        check("ovf_no_dl_wr", dl_wr, 0);
        check("ovf_set", rom_overflow, 1);
        drive(0, 8'd0, 0, 25'd0, 8'h00);
        expect_hold(1'b1);
        check("ovf_sticky", rom_overflow, 1);
        drive(1, 8'd0, 0, 25'd0, 8'h00);
        step();
        check("ovf_cleared_on_entry", rom_overflow, 0);

        // Re-download during HOLD restarts the whole hold.
        drive(1, 8'd0, 1, 25'd5, 8'h42);
        step();
        check("redl_dl_addr", dl_addr, 5);
        drive(0, 8'd0, 0, 25'd0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            step();
            check("redl_core_reset_hold", core_reset, 1);
        end
        drive(1, 8'd0, 0, 25'd0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            step();
            check("redl_core_reset_load", core_reset, 1);
        end
        drive(0, 8'd0, 0, 25'd0, 8'h00);
        expect_hold(1'b1);

        // Async reset in the middle of a ROM download.
        drive(1, 8'd0, 1, 25'd0, 8'h11);
        step();
        drive(1, 8'd0, 1, 25'd1, 8'h22);
        step();
        drive(1, 8'd0, 0, 25'd0, 8'h00);
        do_reset();
        drive(1, 8'd0, 1, 25'd2, 8'h33);
        step();
        check("rstmid_dl_wr", dl_wr, 1);
        check("rstmid_dl_data", dl_data, 8'h33);
        drive(1, 8'd0, 1, 25'd3, 8'h44);
        step();
        check("rstmid_dl_addr", dl_addr, 3);
        drive(0, 8'd0, 0, 25'd0, 8'h00);
        expect_hold(1'b0);

        // Randomized phase.
        idx_pool[0] = 8'd0; idx_pool[1] = 8'd0; idx_pool[2] = 8'd1;
        idx_pool[3] = 8'd254; idx_pool[4] = 8'd9;
        active = 0; ridx = 8'd0; actr = 0;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                active = !active;
                if (active) begin
                    ridx = idx_pool[$urandom_range(0, 4)];
                    actr = 0;
                end
            end
            bus.ioctl_download = active;
            bus.ioctl_index    = ridx;
            bus.ioctl_wr       = active && ($urandom_range(0, 1) == 1);
            if (ridx == 8'd0)
                bus.ioctl_addr = ($urandom_range(0, 15) == 0)
                               ? 25'(25'h20000 + $urandom_range(0, 300)) : actr;
            else
                bus.ioctl_addr = 25'($urandom_range(0, 11));
            bus.ioctl_dout = 8'($urandom);
            if (bus.ioctl_wr) actr = actr + 1'b1;
            user_reset = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 699) == 0) do_reset();
            else step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
